// File: rtl/peripheral_sensor_in.sv
// Memory-mapped sensor input block: 2-flop sync, optional debounce, W1C edge events, level irq.
// Define SENSOR_IN_DEBOUNCE_EN to build the per-channel debounce counters and the DBNC register.
`timescale 1ns/1ps
module peripheral_sensor_in #(
  parameter int N                = 2,
  parameter int DEBOUNCE_DEFAULT = 25000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cs,
  input  logic [4:0]   addr,
  input  logic         rd,
  input  logic         wr,
  input  logic [31:0]  d_in,
  output logic [31:0]  d_out,
  output logic         mem_ready,
  input  logic [N-1:0] sens_in,
  output logic         irq
);

  localparam logic [2:0] REG_STATE  = 3'd0;
  localparam logic [2:0] REG_RAW    = 3'd1;
  localparam logic [2:0] REG_EVENT  = 3'd2;
  localparam logic [2:0] REG_IRQ_EN = 3'd3;
  localparam logic [2:0] REG_DBNC   = 3'd4;

  logic [N-1:0] sync1_reg, sync_reg;
  logic [N-1:0] stable_reg, stable_next;
  logic [N-1:0] rise_reg, rise_next, fall_reg, fall_next;
  logic [N-1:0] ie_rise_reg, ie_fall_reg;
  logic [N-1:0] rise_clr, fall_clr;
  logic [15:0]  dbnc_value;
  logic [2:0]   reg_sel;
  logic         wr_en, rd_en;
  logic [31:0]  rd_mux, rd_data_reg;
  logic         rd_pend_reg;
  logic         unused_ok;

  assign reg_sel   = addr[4:2];
  assign wr_en     = cs & wr;
  assign rd_en     = cs & rd;
  assign unused_ok = &{1'b0, addr[1:0], d_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync_reg  <= '0;
    end else begin
      sync1_reg <= sens_in;
      sync_reg  <= sync1_reg;
    end
  end

`ifdef SENSOR_IN_DEBOUNCE_EN
  logic [15:0] dbnc_reg;
  logic [15:0] thresh_m1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dbnc_reg <= 16'(DEBOUNCE_DEFAULT);
    else if (wr_en && reg_sel == REG_DBNC)
      dbnc_reg <= d_in[15:0];
  end

  // DBNC = 0 behaves as T = 1, so the threshold never underflows.
  assign thresh_m1  = (dbnc_reg == 16'd0) ? 16'd0 : dbnc_reg - 16'd1;
  assign dbnc_value = dbnc_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dbnc
      logic [15:0] count_reg;
      logic        mismatch;
      logic        hit;

      assign mismatch        = sync_reg[gi] ^ stable_reg[gi];
      // >= rather than == so a lowered DBNC takes effect on an already-running count.
      assign hit             = mismatch && (count_reg >= thresh_m1);
      assign stable_next[gi] = hit ? sync_reg[gi] : stable_reg[gi];

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          count_reg <= '0;
        else if (!mismatch || hit)
          count_reg <= '0;
        else
          count_reg <= count_reg + 16'd1;
      end
    end
  endgenerate
`else
  assign stable_next = sync_reg;
  assign dbnc_value  = 16'd0;
`endif

  assign rise_clr  = (wr_en && reg_sel == REG_EVENT) ? d_in[N-1:0]   : '0;
  assign fall_clr  = (wr_en && reg_sel == REG_EVENT) ? d_in[N+7:8]   : '0;
  // New edges are OR-ed in after the clear so a colliding set wins.
  assign rise_next = (rise_reg & ~rise_clr) | (stable_next & ~stable_reg);
  assign fall_next = (fall_reg & ~fall_clr) | (~stable_next & stable_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_reg  <= '0;
      rise_reg    <= '0;
      fall_reg    <= '0;
      ie_rise_reg <= '0;
      ie_fall_reg <= '0;
    end else begin
      stable_reg <= stable_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
      if (wr_en && reg_sel == REG_IRQ_EN) begin
        ie_rise_reg <= d_in[N-1:0];
        ie_fall_reg <= d_in[N+7:8];
      end
    end
  end

  assign irq = |{rise_reg & ie_rise_reg, fall_reg & ie_fall_reg};

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_STATE:  rd_mux[N-1:0] = stable_reg;
      REG_RAW:    rd_mux[N-1:0] = sync_reg;
      REG_EVENT: begin
        rd_mux[N-1:0] = rise_reg;
        rd_mux[N+7:8] = fall_reg;
      end
      REG_IRQ_EN: begin
        rd_mux[N-1:0] = ie_rise_reg;
        rd_mux[N+7:8] = ie_fall_reg;
      end
      REG_DBNC:   rd_mux[15:0] = dbnc_value;
      default:    rd_mux = '0;
    endcase
  end

  // Read data is captured at the strobe edge, so a simultaneous write returns the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_reg <= 1'b0;
      rd_data_reg <= '0;
      d_out       <= '0;
      mem_ready   <= 1'b0;
    end else begin
      rd_pend_reg <= rd_en;
      if (rd_en)
        rd_data_reg <= rd_mux;
      mem_ready <= rd_pend_reg;
      if (rd_pend_reg)
        d_out <= rd_data_reg;
    end
  end

endmodule

// File: tb/tb_peripheral_sensor_in.sv
// Directed bench for peripheral_sensor_in (N=2, DEBOUNCE_DEFAULT=4); adapts to SENSOR_IN_DEBOUNCE_EN.
`timescale 1ns/1ps
module tb_peripheral_sensor_in;

  localparam logic [4:0] A_STATE  = 5'h00;
  localparam logic [4:0] A_RAW    = 5'h04;
  localparam logic [4:0] A_EVENT  = 5'h08;
  localparam logic [4:0] A_IRQ_EN = 5'h0C;
  localparam logic [4:0] A_DBNC   = 5'h10;
`ifdef SENSOR_IN_DEBOUNCE_EN
  localparam int          LAT       = 6;
  localparam logic [31:0] DBNC_RST  = 32'h4;
  localparam logic [31:0] DBNC_FULL = 32'hFFFF;
  localparam logic [31:0] PULSE_EVT = 32'h0;
  localparam int          PULSE_LEN = 3;
`else
  localparam int          LAT       = 3;
  localparam logic [31:0] DBNC_RST  = 32'h0;
  localparam logic [31:0] DBNC_FULL = 32'h0;
  localparam logic [31:0] PULSE_EVT = 32'h101;
  localparam int          PULSE_LEN = 1;
`endif

  logic        clk, rst, cs, rd, wr, mem_ready, irq;
  logic [4:0]  addr;
  logic [31:0] d_in, d_out;
  logic [1:0]  sens_in;
  int          checks = 0;
  int          errors = 0;

  peripheral_sensor_in #(.N(2), .DEBOUNCE_DEFAULT(4)) dut (
    .clk(clk), .rst(rst), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
    .d_in(d_in), .d_out(d_out), .mem_ready(mem_ready),
    .sens_in(sens_in), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    $display("wr   addr %h data %h", a, d);
  endtask

  task automatic bus_read(input logic [4:0] a, input logic [31:0] exp, input string tag);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(mem_ready), 32'h1);
    chk(tag, d_out, exp);
    @(negedge clk);
    chk({tag, "_rdy_end"}, 32'(mem_ready), 32'h0);
  endtask

  // Counts edges from a reference negedge until irq rises; a timeout reports -1.
  task automatic wait_irq(input int start, input int exp, input string tag);
    int e;
    bit seen;
    e = start;
    seen = 1'b0;
    while (!seen && e < start + 20) begin
      @(posedge clk); #1;
      e++;
      if (irq) seen = 1'b1;
    end
    @(negedge clk);
    chk(tag, seen ? 32'(e) : 32'hFFFF_FFFF, 32'(exp));
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0; sens_in = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_ready", 32'(mem_ready), 32'h0);
    chk("rst_dout", d_out, 32'h0);
    rst = 1'b0;

    bus_read(A_STATE,  32'h0, "init_state");
    bus_read(A_RAW,    32'h0, "init_raw");
    bus_read(A_EVENT,  32'h0, "init_event");
    bus_read(A_IRQ_EN, 32'h0, "init_irq_en");
    bus_read(A_DBNC,   DBNC_RST, "init_dbnc");
    for (int i = 5; i < 8; i++) bus_read(5'(i * 4), 32'h0, "init_reserved");

    bus_write(A_IRQ_EN, 32'h001);
    bus_read(A_IRQ_EN, 32'h001, "irq_en_rb");

    sens_in[0] = 1'b1;
    wait_irq(0, LAT, "rise0_latency");
    bus_read(A_STATE, 32'h1,   "rise0_state");
    bus_read(A_RAW,   32'h1,   "rise0_raw");
    bus_read(A_EVENT, 32'h001, "rise0_event");

    bus_write(A_EVENT, 32'h001);
    chk("w1c_irq", 32'(irq), 32'h0);
    bus_read(A_EVENT, 32'h0, "w1c_event");

    sens_in[0] = 1'b0;
    repeat (10) @(negedge clk);
    bus_read(A_EVENT, 32'h100, "fall0_event");
    bus_read(A_STATE, 32'h0,   "fall0_state");
    bus_write(A_EVENT, 32'h100);

    sens_in[0] = 1'b1;
    repeat (PULSE_LEN) @(negedge clk);
    sens_in[0] = 1'b0;
    repeat (10) @(negedge clk);
    bus_read(A_STATE, 32'h0,     "pulse_state");
    bus_read(A_EVENT, PULSE_EVT, "pulse_event");
    bus_write(A_EVENT, 32'h303);

    bus_write(A_IRQ_EN, 32'h200);
    sens_in[1] = 1'b1;
    repeat (10) @(negedge clk);
    bus_read(A_EVENT, 32'h002, "rise1_event");
    chk("rise1_irq_masked", 32'(irq), 32'h0);
    bus_write(A_EVENT, 32'h303);
    sens_in[1] = 1'b0;
    repeat (10) @(negedge clk);
    bus_read(A_EVENT, 32'h200, "fall1_event");
    chk("fall1_irq", 32'(irq), 32'h1);
    bus_write(A_EVENT, 32'h200);
    chk("fall1_clr_irq", 32'(irq), 32'h0);
    bus_read(A_EVENT, 32'h0, "fall1_clr_event");

    sens_in[1] = 1'b1;
    repeat (10) @(negedge clk);
    bus_write(A_EVENT, 32'h303);
    sens_in[1] = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    bus_write(A_EVENT, 32'h200);
    chk("set_wins_irq", 32'(irq), 32'h1);
    bus_read(A_EVENT, 32'h200, "set_wins_event");
    bus_write(A_EVENT, 32'h200);

    bus_write(A_STATE, 32'hFF);
    bus_read(A_STATE, 32'h0, "ro_state");
    bus_write(5'h14, 32'hFFFF_FFFF);
    bus_read(5'h14, 32'h0, "reserved_wr");
    bus_write(A_DBNC, 32'hFFFF);
    bus_read(A_DBNC, DBNC_FULL, "dbnc_rb");
`ifdef SENSOR_IN_DEBOUNCE_EN
    bus_write(A_DBNC, 32'h4);
`endif

    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = A_IRQ_EN; d_in = 32'h101;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    chk("rdwr_old_value", d_out, 32'h200);
    @(negedge clk);
    bus_read(A_IRQ_EN, 32'h101, "rdwr_new_value");

`ifdef SENSOR_IN_DEBOUNCE_EN
    bus_write(A_DBNC, 32'h7);
`endif
    sens_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = A_STATE;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_irq", 32'(irq), 32'h0);
    chk("midrst_ready", 32'(mem_ready), 32'h0);
    chk("midrst_dout", d_out, 32'h0);
    @(negedge clk);
    chk("midrst_ready_dropped", 32'(mem_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_write(A_IRQ_EN, 32'h001);
    wait_irq(1, LAT, "post_rst_latency");
    bus_read(A_DBNC,  DBNC_RST, "post_rst_dbnc");
    bus_read(A_EVENT, 32'h001,  "post_rst_event");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
